// File: rtl/select_arbiter_if.sv
// Bundle of request, output and debug signals shared between the round-robin
// arbiter and the logic around it.
//
// Handshake: a beat moves across a channel on a rising clk edge where both
// valid and ready are high. Requester i sees req_ready[i] high only when the
// arbiter grants it and the output stage can take a beat. A requester raises
// valid only when it has a beat. It then keeps valid, last and data steady
// until the beat is taken. The one exception is a requester that already holds
// the grant in the middle of a burst: it may drop valid, which inserts a bubble.
// out_valid/out_data/out_last/out_sel stay steady while out_valid is high and
// out_ready is low.
interface select_arbiter_if #(
  parameter int NUM_SEL   = 16,
  parameter int NUM_LOG   = 4,
  parameter int NUM_WIDTH = 64
);
  logic [NUM_SEL-1:0]           req_valid;
  logic [NUM_SEL-1:0]           req_last;
  logic [NUM_WIDTH*NUM_SEL-1:0] req_data;
  logic [NUM_SEL-1:0]           req_ready;
  logic                         out_valid;
  logic [NUM_WIDTH-1:0]         out_data;
  logic                         out_last;
  logic [NUM_LOG-1:0]           out_sel;
  logic                         out_ready;
  logic                         busy;
  // Debug view of the arbiter FSM: 0 = IDLE, 1 = LOCKED.
  logic                         dbg_state;
  logic [NUM_LOG-1:0]           dbg_ptr;

  // Arbiter side.
  modport slave (
    input  req_valid, req_last, req_data, out_ready,
    output req_ready, out_valid, out_data, out_last, out_sel, busy,
           dbg_state, dbg_ptr
  );

  // Requesters plus downstream consumer side.
  modport master (
    output req_valid, req_last, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_last, out_sel, busy,
           dbg_state, dbg_ptr
  );
endinterface

// File: rtl/select_arbiter.sv
// Round-robin arbiter merging NUM_SEL valid/ready beat streams into one
// registered output stage. A grant is held for a whole burst, up to and
// including the beat flagged last. Indices at or above NUM_SEL are never
// granted.

// NUM_SEL-to-1 beat mux. An out-of-range select yields zero.
module select #(
  parameter int NUM_SEL   = 16,
  parameter int NUM_LOG   = 4,
  parameter int NUM_WIDTH = 64
) (
  input  logic [NUM_LOG-1:0]           sel,
  input  logic [NUM_WIDTH*NUM_SEL-1:0] data,
  output logic [NUM_WIDTH-1:0]         y
);
  // Pick the slice addressed by sel.
  always_comb begin
    y = '0;
    for (int i = 0; i < NUM_SEL; i++) begin
      if (sel == NUM_LOG'(i)) y = data[NUM_WIDTH*i +: NUM_WIDTH];
    end
  end
endmodule

module select_arbiter #(
  parameter int NUM_SEL   = 16,
  parameter int NUM_LOG   = 4,
  parameter int NUM_WIDTH = 64
) (
  input logic             clk,
  input logic             rst_n,
  select_arbiter_if.slave bus
);
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t               state;
  logic [NUM_LOG-1:0]   ptr;
  logic [NUM_LOG-1:0]   lock_sel;
  logic                 out_valid;
  logic [NUM_WIDTH-1:0] out_data;
  logic                 out_last;
  logic [NUM_LOG-1:0]   out_sel;

  logic                 can_load;
  logic                 rr_found;
  logic [NUM_LOG-1:0]   rr_idx;
  logic                 grant_valid;
  logic [NUM_LOG-1:0]   grant_idx;
  logic [NUM_SEL-1:0]   req_ready;
  logic                 xfer;
  logic                 grant_last;
  logic [NUM_WIDTH-1:0] mux_data;

  // Successor index with wrap from NUM_SEL-1 back to 0.
  function automatic logic [NUM_LOG-1:0] next_idx(input logic [NUM_LOG-1:0] idx);
    return (idx == NUM_LOG'(NUM_SEL - 1)) ? '0 : idx + 1'b1;
  endfunction

  // The output stage can take a new beat when it is empty or draining this cycle.
  assign can_load = ~out_valid | bus.out_ready;

  // Round-robin search: first valid at or above ptr, otherwise first valid below ptr.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int i = 0; i < NUM_SEL; i++) begin
      if (!rr_found && (i >= int'(ptr)) && bus.req_valid[i]) begin
        rr_found = 1'b1;
        rr_idx   = NUM_LOG'(i);
      end
    end
    for (int i = 0; i < NUM_SEL; i++) begin
      if (!rr_found && (i < int'(ptr)) && bus.req_valid[i]) begin
        rr_found = 1'b1;
        rr_idx   = NUM_LOG'(i);
      end
    end
  end

  // Grant source: the round-robin winner in IDLE, the locked requester in LOCKED.
  always_comb begin
    grant_valid = 1'b1;
    grant_idx   = lock_sel;
    if (state == IDLE) begin
      grant_valid = rr_found;
      grant_idx   = rr_idx;
    end
  end

  // One-hot ready toward the granted requester. It is forced low in reset and under backpressure.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_SEL; i++) begin
      if (rst_n && grant_valid && can_load && (grant_idx == NUM_LOG'(i))) req_ready[i] = 1'b1;
    end
  end

  // req_ready is one-hot, so masking gives the transfer and its last flag without a second index.
  assign xfer       = |(bus.req_valid & req_ready);
  assign grant_last = |(bus.req_last & req_ready);

  select #(
    .NUM_SEL   (NUM_SEL),
    .NUM_LOG   (NUM_LOG),
    .NUM_WIDTH (NUM_WIDTH)
  ) u_select (
    .sel  (grant_idx),
    .data (bus.req_data),
    .y    (mux_data)
  );

  // Arbiter FSM, round-robin pointer and output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      lock_sel  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= mux_data;
      out_last  <= grant_last;
      out_sel   <= grant_idx;
      if (grant_last) begin
        ptr   <= next_idx(grant_idx);
        state <= IDLE;
      end else begin
        lock_sel <= grant_idx;
        state    <= LOCKED;
      end
    end else if (out_valid && bus.out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_last  = out_last;
  assign bus.out_sel   = out_sel;
  assign bus.busy      = (state == LOCKED) | out_valid;
  assign bus.dbg_state = state;
  assign bus.dbg_ptr   = ptr;
endmodule

// File: doc/select_arbiter.md
# select_arbiter

Round-robin arbiter that shares one NUM_SEL-to-1 output channel among NUM_SEL requesters, each presenting NUM_WIDTH-bit beats with a valid/ready handshake. It computes the grant index, drives the shared `select` mux with it, and registers the winning beat into a single output stage. Grant is held for a whole burst until the requester's `last` beat is transferred. In the decompressor it merges the per-lane output streams into one stream toward the write-back path.

## Interface
- `NUM_SEL`, 16: number of requesters; must be ≤ 2^NUM_LOG.
- `NUM_LOG`, 4: width of the grant index.
- `NUM_WIDTH`, 64: beat width in bits.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `req_valid`  in  NUM_SEL  bit i: requester i presents a beat.
- `req_last`  in  NUM_SEL  bit i: requester i's beat ends its burst.
- `req_data`  in  NUM_WIDTH*NUM_SEL  requester i's beat in slice [NUM_WIDTH*i +: NUM_WIDTH].
- `req_ready`  out  NUM_SEL  one-hot or zero; bit i high means requester i's beat is taken this cycle if its valid is high.
- `out_valid`  out  1  output register holds a beat.
- `out_data`  out  NUM_WIDTH  registered beat.
- `out_last`  out  1  registered `last` flag.
- `out_sel`  out  NUM_LOG  index of the requester that produced `out_data`.
- `out_ready`  in  1  downstream accepts the beat.
- `busy`  out  1  high in LOCKED or while `out_valid` is high.

## Operation
- **Transfer rules.**
  - A requester transfer occurs when `req_valid[g] & req_ready[g]`.
  - An output transfer occurs when `out_valid & out_ready`.
  - `can_load` = `~out_valid | out_ready`.
- **State machine:** IDLE and LOCKED. Registered pointer `ptr` (NUM_LOG bits). `lock_sel` holds the locked index.
- **IDLE.**
  - Winner g is the first index with `req_valid` high, searching ptr, ptr+1, …, NUM_SEL-1, 0, …, ptr-1.
  - `req_ready[g] = can_load`. All other bits are 0. If no valid is high, `req_ready` is all 0.
  - Transfer with `req_last[g]=1`: `ptr` ← g+1 with wrap (NUM_SEL-1 → 0). Stay in IDLE.
  - Transfer with `req_last[g]=0`: `lock_sel` ← g and go to LOCKED.
- **LOCKED.**
  - Grant is `lock_sel` only. `req_ready[lock_sel] = can_load`. Other requesters are ignored even if valid.
  - If `req_valid[lock_sel]` is low, nothing is granted (bubble) and the state stays LOCKED.
  - Transfer with `req_last=1`: `ptr` ← `lock_sel`+1 with wrap, then go to IDLE.
- **Datapath.**
  - The grant index drives an internal `select` (NUM_SEL, NUM_LOG, NUM_WIDTH) instance on `req_data`.
  - On a requester transfer: `out_data` ← mux output, `out_last` ← `req_last[g]`, `out_sel` ← g, `out_valid` ← 1.
  - Else on an output transfer: `out_valid` ← 0. `out_data`, `out_last` and `out_sel` keep their values.
  - Simultaneous output transfer and requester transfer: the register is reloaded and `out_valid` stays 1 (full throughput).
- **Backpressure.** If `out_valid=1` and `out_ready=0`, all `req_ready` are 0. The output register holds stable, and `ptr` and the state are frozen.
- **Reset, any cycle including mid-burst.**
  - State ← IDLE, `ptr` ← 0, `lock_sel` ← 0.
  - `out_valid` ← 0, `out_data` ← 0, `out_last` ← 0, `out_sel` ← 0.
  - `req_ready` is forced to 0 while `rst_n=0`.
  - A partially sent burst is not resumed. Requesters re-arbitrate from index 0.
- Indices ≥ NUM_SEL never win and never appear on `out_sel`.

## Timing
- `req_ready` is combinational from `req_valid`, state, `ptr`, `out_valid` and `out_ready`. There is no path from `req_data` to `req_ready`.
- Latency: a requester transfer in cycle n gives `out_valid=1` with that beat in cycle n+1.
- Throughput: 1 beat per cycle while `out_ready=1`, including across burst boundaries. The next winner is granted in the cycle after the `last` transfer.
- All outputs except `req_ready` come directly from flops.
- `busy` is registered-equivalent, derived only from the state and `out_valid`.

## Test plan
- **Reset and idle:** hold `rst_n=0` for 3 cycles with all `req_valid`=16'hFFFF → `req_ready`=0, `out_valid`=0, `out_sel`=0. Release with `req_valid`=0 → outputs stay 0, `busy`=0.
- **Round-robin with wrap:** requesters 3, 7 and 15 each send single-beat bursts (last=1), data = index, `out_ready`=1.
  - `out_sel` sequence is 3, 7, 15, 3, 7, 15.
  - Beat rate is 1 per cycle.
  - `ptr` wraps 15 → 0.
- **Burst lock:** requester 2 sends 4 beats (last on beat 4) while requester 5 is valid throughout.
  - Output is 2, 2, 2, 2, 5.
  - Deassert `req_valid[2]` for 2 cycles mid-burst → 2 bubble cycles with requester 5 still not granted.
- **Backpressure:** `out_ready`=0 for 5 cycles while `out_valid`=1 with data 64'hA5A5_0000_0000_0001 → `out_data` is stable and `req_ready`=0. `out_ready`=1 → the next beat appears the following cycle.
- **Reset mid-burst:** assert `rst_n=0` on beat 2 of a 4-beat burst from requester 9 with requester 1 also valid → after release, the first grant is 1 (ptr=0), not 9.
- **Scoreboard soak:** 10,000 random cycles of valid, last and `out_ready` across 16 requesters.
  - Per-requester beat order is preserved.
  - No interleaving inside a burst.
  - Grant gap between bursts is ≤ 15 bursts for any continuously valid requester.
